// File: rtl/integral_image_gen_pkg.sv
// Shared types and width helpers for the integral-image generator.
package ii_pkg;

   // End-of-transfer tag carried with each output word (bit1 frame, bit0 row).
   typedef struct packed {
      logic frame_end;
      logic row_end;
   } eot_t;

   // Index width for a counter or array of n entries (at least 1 bit).
   function automatic int unsigned addr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Minimum ii width: full-frame sum of max-valued pixels.
   function automatic int unsigned min_w_ii(input int unsigned w_pix,
                                            input int unsigned width,
                                            input int unsigned height);
      longint unsigned max_p;
      longint unsigned total;
      max_p = (64'd1 << w_pix) - 64'd1;
      total = 64'(width) * 64'(height) * max_p;
      return $clog2(total + 64'd1);
   endfunction

   // Minimum sii width: full-frame sum of squared max-valued pixels.
   function automatic int unsigned min_w_sii(input int unsigned w_pix,
                                             input int unsigned width,
                                             input int unsigned height);
      longint unsigned max_p;
      longint unsigned total;
      max_p = (64'd1 << w_pix) - 64'd1;
      total = 64'(width) * 64'(height) * max_p * max_p;
      return $clog2(total + 64'd1);
   endfunction

endpackage

// File: rtl/integral_image_gen_line_buffer.sv
// One-row line buffer: combinational read and synchronous write at the same column.
// Contents are intentionally not reset; the caller masks them on row 0.
module ii_line_buffer
   import ii_pkg::*;
#(
   parameter int unsigned DEPTH  = 25,
   parameter int unsigned W_DATA = 18,
   localparam int unsigned W_ADDR = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [W_ADDR-1:0] i_addr,
   input  logic [W_DATA-1:0] i_wdata,
   output logic [W_DATA-1:0] o_rdata
);

   logic [W_DATA-1:0] r_mem [DEPTH];

   assign o_rdata = r_mem[i_addr];

   // Store the freshly computed column value for use by the next row.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

endmodule

// File: rtl/integral_image_gen.sv
// Streaming integral-image (ii) and squared integral-image (sii) generator.
// Optional sii path is enabled by defining INTEGRAL_IMAGE_SII_EN; without it
// the sii outputs are tied to zero and sii_ready is ignored.
module integral_image_gen
   import ii_pkg::*;
#(
   parameter int unsigned W_PIXEL    = 8,
   parameter int unsigned IMG_WIDTH  = 25,
   parameter int unsigned IMG_HEIGHT = 25,
   parameter int unsigned W_II       = 18,
   parameter int unsigned W_SII      = 26
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_valid,
   output logic               pix_ready,
   input  logic [W_PIXEL-1:0] pix_data,
   output logic               ii_valid,
   input  logic               ii_ready,
   output logic [W_II-1:0]    ii_data,
   output logic [1:0]         ii_eot,
   output logic               sii_valid,
   input  logic               sii_ready,
   output logic [W_SII-1:0]   sii_data,
   output logic [1:0]         sii_eot
);

   localparam int unsigned W_COL = addr_w(IMG_WIDTH);
   localparam int unsigned W_ROW = addr_w(IMG_HEIGHT);
   localparam logic [W_COL-1:0] COL_LAST = W_COL'(IMG_WIDTH - 1);
   localparam logic [W_ROW-1:0] ROW_LAST = W_ROW'(IMG_HEIGHT - 1);

   if (W_II < min_w_ii(W_PIXEL, IMG_WIDTH, IMG_HEIGHT)) begin : g_w_ii_err
      $error("integral_image_gen: W_II too narrow for the frame size");
   end
   if (W_SII < min_w_sii(W_PIXEL, IMG_WIDTH, IMG_HEIGHT)) begin : g_w_sii_err
      $error("integral_image_gen: W_SII too narrow for the frame size");
   end

   logic [W_COL-1:0] r_col;
   logic [W_ROW-1:0] r_row;
   logic [W_II-1:0]  r_rs;
   logic             r_ii_valid;
   logic [W_II-1:0]  r_ii_data;
   eot_t             r_ii_eot;

   logic             w_accept;
   logic             w_ii_free;
   logic             w_sii_free;
   logic             w_first_col;
   logic             w_first_row;
   eot_t             w_eot;
   logic [W_II-1:0]  w_rs_new;
   logic [W_II-1:0]  w_lb_ii;
   logic [W_II-1:0]  w_ii_new;

   assign w_ii_free   = !r_ii_valid | ii_ready;
   assign pix_ready   = w_ii_free & w_sii_free;
   assign w_accept    = pix_valid & pix_ready;
   assign w_first_col = (r_col == '0);
   assign w_first_row = (r_row == '0);
   assign w_eot.row_end   = (r_col == COL_LAST);
   assign w_eot.frame_end = (r_col == COL_LAST) & (r_row == ROW_LAST);

   assign w_rs_new = w_first_col ? W_II'(pix_data) : r_rs + W_II'(pix_data);
   assign w_ii_new = w_rs_new + (w_first_row ? {W_II{1'b0}} : w_lb_ii);

   ii_line_buffer #(.DEPTH(IMG_WIDTH), .W_DATA(W_II)) u_lb_ii (
      .clk     (clk),
      .i_we    (w_accept),
      .i_addr  (r_col),
      .i_wdata (w_ii_new),
      .o_rdata (w_lb_ii)
   );

   // Raster position of the next pixel; wraps straight into the next frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + W_ROW'(1);
         end else begin
            r_col <= r_col + W_COL'(1);
         end
      end
   end

   // Running row sum, restarted by the first pixel of each row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rs <= '0;
      end else if (w_accept) begin
         r_rs <= w_rs_new;
      end
   end

   // ii output register: load on accept, drop valid once taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ii_valid <= 1'b0;
         r_ii_data  <= '0;
         r_ii_eot   <= '0;
      end else if (w_accept) begin
         r_ii_valid <= 1'b1;
         r_ii_data  <= w_ii_new;
         r_ii_eot   <= w_eot;
      end else if (ii_ready) begin
         r_ii_valid <= 1'b0;
      end
   end

   assign ii_valid = r_ii_valid;
   assign ii_data  = r_ii_data;
   assign ii_eot   = r_ii_eot;

`ifdef INTEGRAL_IMAGE_SII_EN
   logic [W_SII-1:0] r_rss;
   logic             r_sii_valid;
   logic [W_SII-1:0] r_sii_data;
   eot_t             r_sii_eot;
   logic [W_SII-1:0] w_pix_sq;
   logic [W_SII-1:0] w_rss_new;
   logic [W_SII-1:0] w_lb_sii;
   logic [W_SII-1:0] w_sii_new;

   assign w_sii_free = !r_sii_valid | sii_ready;
   assign w_pix_sq   = W_SII'(pix_data) * W_SII'(pix_data);
   assign w_rss_new  = w_first_col ? w_pix_sq : r_rss + w_pix_sq;
   assign w_sii_new  = w_rss_new + (w_first_row ? {W_SII{1'b0}} : w_lb_sii);

   ii_line_buffer #(.DEPTH(IMG_WIDTH), .W_DATA(W_SII)) u_lb_sii (
      .clk     (clk),
      .i_we    (w_accept),
      .i_addr  (r_col),
      .i_wdata (w_sii_new),
      .o_rdata (w_lb_sii)
   );

   // Running row sum of squares, restarted by the first pixel of each row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rss <= '0;
      end else if (w_accept) begin
         r_rss <= w_rss_new;
      end
   end

   // sii output register: independent of the ii register once its word is taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sii_valid <= 1'b0;
         r_sii_data  <= '0;
         r_sii_eot   <= '0;
      end else if (w_accept) begin
         r_sii_valid <= 1'b1;
         r_sii_data  <= w_sii_new;
         r_sii_eot   <= w_eot;
      end else if (sii_ready) begin
         r_sii_valid <= 1'b0;
      end
   end

   assign sii_valid = r_sii_valid;
   assign sii_data  = r_sii_data;
   assign sii_eot   = r_sii_eot;
`else
   logic w_unused_sii_ready;

   assign w_unused_sii_ready = sii_ready;
   assign w_sii_free = 1'b1;
   assign sii_valid  = 1'b0;
   assign sii_data   = '0;
   assign sii_eot    = 2'b00;
`endif

endmodule

// File: tb/tb_integral_image_gen.sv
// Self-checking bench for integral_image_gen: directed test-plan scenarios,
// randomized handshakes against a rectangle-sum reference model, and a
// full-size max-value frame.
module tb_integral_image_gen;

   localparam int unsigned AW = 3;
   localparam int unsigned AH = 2;
`ifdef INTEGRAL_IMAGE_SII_EN
   localparam logic SR_ON = 1'b1;
`else
   localparam logic SR_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Small 3x2 instance
   logic        a_pix_valid, a_pix_ready, a_ii_valid, a_ii_ready, a_sii_valid, a_sii_ready;
   logic [7:0]  a_pix_data;
   logic [17:0] a_ii_data;
   logic [25:0] a_sii_data;
   logic [1:0]  a_ii_eot, a_sii_eot;

   // Full-size 25x25 instance
   logic        b_pix_valid, b_pix_ready, b_ii_valid, b_ii_ready, b_sii_valid, b_sii_ready;
   logic [7:0]  b_pix_data;
   logic [17:0] b_ii_data;
   logic [25:0] b_sii_data;
   logic [1:0]  b_ii_eot, b_sii_eot;

   integral_image_gen #(.W_PIXEL(8), .IMG_WIDTH(AW), .IMG_HEIGHT(AH), .W_II(18), .W_SII(26)) u_dut_a (
      .clk(clk), .rst(rst),
      .pix_valid(a_pix_valid), .pix_ready(a_pix_ready), .pix_data(a_pix_data),
      .ii_valid(a_ii_valid), .ii_ready(a_ii_ready), .ii_data(a_ii_data), .ii_eot(a_ii_eot),
      .sii_valid(a_sii_valid), .sii_ready(a_sii_ready), .sii_data(a_sii_data), .sii_eot(a_sii_eot)
   );

   integral_image_gen #(.W_PIXEL(8), .IMG_WIDTH(25), .IMG_HEIGHT(25), .W_II(18), .W_SII(26)) u_dut_b (
      .clk(clk), .rst(rst),
      .pix_valid(b_pix_valid), .pix_ready(b_pix_ready), .pix_data(b_pix_data),
      .ii_valid(b_ii_valid), .ii_ready(b_ii_ready), .ii_data(b_ii_data), .ii_eot(b_ii_eot),
      .sii_valid(b_sii_valid), .sii_ready(b_sii_ready), .sii_data(b_sii_data), .sii_eot(b_sii_eot)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Reference model state: expected output registers plus the current frame's pixels.
   logic            m_ii_v, m_sii_v;
   longint unsigned m_ii_d, m_sii_d;
   logic [1:0]      m_eot;
   int              mrow, mcol;
   int              img [AH][AW];

   longint unsigned obs_ii[$];
   longint unsigned obs_sii[$];

   task automatic chk(input string tag, input longint unsigned act, input longint unsigned exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic chk_seq(input string tag, input longint unsigned got[$], input longint unsigned exp[$]);
      chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         chk(tag, got[i], exp[i]);
      end
   endtask

   task automatic model_reset();
      m_ii_v  = 1'b0;
      m_sii_v = 1'b0;
      mrow    = 0;
      mcol    = 0;
   endtask

   // ii/sii as plain rectangle sums over the pixels seen so far in this frame.
   task automatic model_push(input int p);
      longint unsigned s, ss;
      img[mrow][mcol] = p;
      s  = 0;
      ss = 0;
      for (int r = 0; r <= mrow; r++) begin
         for (int c = 0; c <= mcol; c++) begin
            s  += 64'(img[r][c]);
            ss += 64'(img[r][c]) * 64'(img[r][c]);
         end
      end
      m_ii_v  = 1'b1;
      m_sii_v = 1'b1;
      m_ii_d  = s;
      m_sii_d = ss;
      m_eot   = {(mcol == AW - 1) && (mrow == AH - 1), mcol == AW - 1};
      mcol++;
      if (mcol == AW) begin
         mcol = 0;
         mrow = (mrow + 1) % AH;
      end
   endtask

   // One clock of the small instance, entered and left at a falling edge.
   task automatic step(input logic v, input logic [7:0] d, input logic ir, input logic sr, output logic acc);
      logic exp_rdy;
      chk("ii_valid", 64'(a_ii_valid), 64'(m_ii_v));
      if (m_ii_v) begin
         chk("ii_data", 64'(a_ii_data), m_ii_d);
         chk("ii_eot", 64'(a_ii_eot), 64'(m_eot));
      end
`ifdef INTEGRAL_IMAGE_SII_EN
      chk("sii_valid", 64'(a_sii_valid), 64'(m_sii_v));
      if (m_sii_v) begin
         chk("sii_data", 64'(a_sii_data), m_sii_d);
         chk("sii_eot", 64'(a_sii_eot), 64'(m_eot));
      end
`else
      chk("sii_valid_off", 64'(a_sii_valid), 64'd0);
      chk("sii_data_off", 64'(a_sii_data), 64'd0);
      chk("sii_eot_off", 64'(a_sii_eot), 64'd0);
`endif
      if (a_ii_valid && ir) obs_ii.push_back(64'(a_ii_data));
      if (a_sii_valid && sr) obs_sii.push_back(64'(a_sii_data));
      a_pix_valid = v;
      a_pix_data  = d;
      a_ii_ready  = ir;
      a_sii_ready = sr;
      #1;
`ifdef INTEGRAL_IMAGE_SII_EN
      exp_rdy = (!m_ii_v || ir) && (!m_sii_v || sr);
`else
      exp_rdy = !m_ii_v || ir;
`endif
      chk("pix_ready", 64'(a_pix_ready), 64'(exp_rdy));
      acc = v && exp_rdy;
      if (acc) begin
         model_push(int'(d));
      end else begin
         if (ir) m_ii_v = 1'b0;
         if (sr) m_sii_v = 1'b0;
      end
      @(negedge clk);
   endtask

   // Offer one pixel until accepted; returns cycles used.
   task automatic feed(input int p, input logic ir, input logic sr, output int tries);
      logic acc;
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 20) begin
         step(1'b1, 8'(p), ir, sr, acc);
         tries++;
      end
      if (!acc) chk("feed_timeout", 64'(tries), 64'd0);
   endtask

   task automatic flush();
      logic acc;
      for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b1, 1'b1, acc);
   endtask

   task automatic clear_obs();
      obs_ii.delete();
      obs_sii.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint unsigned e_ii[$];
      longint unsigned e_sii[$];
      logic acc;
      int   tries, k, cyc, bnr;

      rst = 1'b0;
      a_pix_valid = 1'b0; a_pix_data = '0; a_ii_ready = 1'b0; a_sii_ready = 1'b0;
      b_pix_valid = 1'b0; b_pix_data = '0; b_ii_ready = 1'b1; b_sii_ready = SR_ON;
      model_reset();
      #2;
      chk("rst_ii_valid", 64'(a_ii_valid), 64'd0);
      chk("rst_ii_data", 64'(a_ii_data), 64'd0);
      chk("rst_ii_eot", 64'(a_ii_eot), 64'd0);
      chk("rst_sii_valid", 64'(a_sii_valid), 64'd0);
      chk("rst_sii_data", 64'(a_sii_data), 64'd0);
      chk("rst_pix_ready", 64'(a_pix_ready), 64'd1);
      @(negedge clk);
      rst = 1'b1;

      // Single frame 1..6 with both readies high
      clear_obs();
      for (int p = 1; p <= 6; p++) feed(p, 1'b1, SR_ON, tries);
      flush();
      e_ii  = '{1, 3, 6, 5, 12, 21};
      e_sii = '{1, 5, 14, 17, 46, 91};
      chk_seq("s1_ii", obs_ii, e_ii);
`ifdef INTEGRAL_IMAGE_SII_EN
      chk_seq("s1_sii", obs_sii, e_sii);
`endif

      // Two back-to-back frames with no bubble
      clear_obs();
      for (int f = 0; f < 2; f++) begin
         for (int p = 1; p <= 6; p++) begin
            feed(p, 1'b1, SR_ON, tries);
            chk("b2b_no_bubble", 64'(tries), 64'd1);
         end
      end
      flush();
      chk_seq("b2b_ii", obs_ii, {e_ii, e_ii});
`ifdef INTEGRAL_IMAGE_SII_EN
      chk_seq("b2b_sii", obs_sii, {e_sii, e_sii});
`endif

      // ii stalled for 3 cycles after word 2, sii always ready
      clear_obs();
      k = 0;
      cyc = 0;
      while (k < 6 && cyc < 40) begin
         step(1'b1, 8'(k + 1), (cyc >= 2 && cyc <= 4) ? 1'b0 : 1'b1, 1'b1, acc);
         if (acc) k++;
         cyc++;
      end
      chk("stall_accepts", 64'(k), 64'd6);
      chk("stall_cycles", 64'(cyc), 64'd9);
      flush();
      chk_seq("stall_ii", obs_ii, e_ii);
`ifdef INTEGRAL_IMAGE_SII_EN
      chk_seq("stall_sii", obs_sii, e_sii);
`endif

      // Asynchronous reset after pixel 4, then a fresh frame
      for (int p = 1; p <= 4; p++) feed(p, 1'b1, SR_ON, tries);
      a_pix_valid = 1'b0;
      chk("pre_rst_ii_valid", 64'(a_ii_valid), 64'd1);
      rst = 1'b0;
      #1;
      chk("async_rst_ii_valid", 64'(a_ii_valid), 64'd0);
      chk("async_rst_sii_valid", 64'(a_sii_valid), 64'd0);
      chk("async_rst_pix_ready", 64'(a_pix_ready), 64'd1);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_obs();
      for (int p = 7; p <= 9; p++) feed(p, 1'b1, SR_ON, tries);
      flush();
      chk_seq("rst_ii", obs_ii, '{7, 15, 24});
`ifdef INTEGRAL_IMAGE_SII_EN
      chk_seq("rst_sii", obs_sii, '{49, 113, 194});
`endif

      // Randomized pixels and handshakes
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255)),
              ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, acc);
      end
      flush();

      // Full-size frame of max-valued pixels
      bnr = 0;
      for (int i = 0; i < 625; i++) begin
         if (i == 25) begin
            chk("max_row0_ii", 64'(b_ii_data), 64'd6375);
            chk("max_row0_eot", 64'(b_ii_eot), 64'd1);
         end
         b_pix_valid = 1'b1;
         b_pix_data  = 8'd255;
         #1;
         if (!b_pix_ready) bnr++;
         @(negedge clk);
      end
      b_pix_valid = 1'b0;
      chk("max_stalls", 64'(bnr), 64'd0);
      chk("max_ii_valid", 64'(b_ii_valid), 64'd1);
      chk("max_ii_data", 64'(b_ii_data), 64'd159375);
      chk("max_ii_eot", 64'(b_ii_eot), 64'd3);
`ifdef INTEGRAL_IMAGE_SII_EN
      chk("max_sii_data", 64'(b_sii_data), 64'd40640625);
      chk("max_sii_eot", 64'(b_sii_eot), 64'd3);
`else
      chk("max_sii_valid_off", 64'(b_sii_valid), 64'd0);
`endif
      @(negedge clk);
      chk("max_ii_drain", 64'(b_ii_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
